ddr_port_arbiter: RTL and testbench
===================================

Name: ddr_port_arbiter

Overview:
- Shares one MIG user interface (app_* signals, 128-bit UI data) between NUM_PORTS burst requesters (camera write channels, display read channels, etc.).
- Each requester asks for one linear burst: direction, start address, length in beats.
- The arbiter grants round-robin, issues the commands and streams write data from the granted port.
- Read return data is routed back to the issuing port in order, via a tag FIFO.
- Sits between the per-channel frame-buffer address sequencers and the MIG core, all in the ui_clk domain.

Parameters:
- ADDR_WIDTH, 28, MIG app_addr width.
- APP_DATA_WIDTH, 128, MIG UI data width.
- NUM_PORTS, 4, number of requesters (2..8).
- LEN_WIDTH, 16, width of burst length in beats.
- ADDR_STEP, 8, app_addr increment per beat.
- TAG_DEPTH, 4, maximum number of outstanding read bursts (power of 2).

Ports:
- ui_clk  in  1  sole clock.
- ui_rst_i  in  1  synchronous, active-high reset.
- req_i  in  NUM_PORTS  burst request, level; held until done_o.
- req_wr_i  in  NUM_PORTS  1 = write burst, 0 = read burst.
- req_addr_i  in  NUM_PORTS*ADDR_WIDTH  burst start address, packed per port.
- req_len_i  in  NUM_PORTS*LEN_WIDTH  burst length in beats.
- wdata_i  in  NUM_PORTS*APP_DATA_WIDTH  write data, FWFT FIFO heads.
- wdata_pop_o  out  NUM_PORTS  pop strobe for the granted write FIFO.
- grant_o  out  NUM_PORTS  one-hot, high while that port's burst is issuing.
- done_o  out  NUM_PORTS  1-cycle pulse when the last command of a burst is accepted.
- rdata_o  out  APP_DATA_WIDTH  read data, shared by all ports.
- rdata_vld_o  out  NUM_PORTS  one-hot qualifier for rdata_o.
- err_o  out  1  sticky: read beat arrived with no outstanding tag.
- app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end  out  MIG widths  MIG command and write interface.
- app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid  in  MIG widths  MIG status and read data.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer at port 0, tag FIFO emptied, err_o cleared. Read beats that arrive after reset with the tag FIFO empty are dropped and set err_o.
- FSM states: IDLE, ARB, WR, RD, DONE.
- IDLE -> ARB when any port is eligible. A port is eligible when req_i is high and it is either a write, or a read with the tag FIFO not full.
- ARB, one cycle:
  - Select the first eligible port at or after rr_ptr.
  - Latch its address, length and direction; assert grant_o from the next cycle.
  - Set rr_ptr = selected + 1, wrapping at NUM_PORTS.
  - len = 0 -> go to DONE with no command issued.
  - Read burst: push {port, len} to the tag FIFO.
  - Go to WR or RD.
- WR:
  - app_en = app_wdf_wren = app_wdf_end = wdata_pop_o[g] = app_rdy & app_wdf_rdy.
  - app_cmd = 3'd0.
  - app_wdf_data = wdata_i slice of the granted port, passed through combinationally.
- RD:
  - app_en = app_rdy; app_cmd = 3'd1.
- Command handshake (WR and RD):
  - On each accepted beat, address += ADDR_STEP (modulo 2^ADDR_WIDTH, wraps silently) and beat count += 1.
  - When beat count reaches len-1 and a beat is accepted -> DONE.
- DONE, one cycle: done_o[g] pulses, grant_o drops, return to IDLE. A port sees at least one idle cycle between bursts.
- req_i deassertion mid-burst is ignored; the latched burst always completes.
- Read return path:
  - On app_rd_data_valid with tag FIFO non-empty: rdata_o = app_rd_data registered, one cycle latency; rdata_vld_o[head.port] = 1.
  - Head remaining count decrements; pop the head on its last beat.
  - Push and pop in the same cycle are both honoured.
  - Read beats continue to flow while a write burst is being issued.
- Tag FIFO full blocks new read grants only; writes are still granted.

Optional Feature:
- DDR_ARB_WR_PRIORITY_EN defined: in ARB, any eligible write port beats every read port, with round-robin applied among writes, then among reads. This protects camera ingress from overflow.
- Not defined: pure round-robin across all ports regardless of direction.

Decomposition:
- Package ddr_arb_pkg holds:
  - CMD_WRITE = 3'd0, CMD_READ = 3'd1.
  - The FSM state enum.
  - The tag struct {port index, LEN_WIDTH count}.
  - The round-robin select function.
- One sub-module: ddr_rd_tag_fifo, a synchronous FIFO of depth TAG_DEPTH with full/empty and a remaining-beat counter on the head entry.

Test Plan:
- Port 0 write len 4, addr 0x100, app_rdy/app_wdf_rdy always 1 -> 4 app_en beats at addresses 0x100, 0x108, 0x110, 0x118; 4 pops; done_o[0] pulse on cycle 4 after grant.
- Write len 3 with app_wdf_rdy low every other cycle -> no beat, pop or address advance while it is low; exactly 3 beats total.
- Ports 1 and 2 both reading, len 2 each, MIG returns 4 beats -> rdata_vld_o = 0010, 0010, 0100, 0100; grant order 1 then 2; next grant goes to 3 or 0 by rr_ptr.
- 5 read requests with TAG_DEPTH 4 and no return data -> 5th port not granted until the first tag pops; a pending write is still granted.
- len 0 request -> done_o pulse, no app_en. Also assert ui_rst_i mid-burst -> all outputs 0 the next cycle; a stray app_rd_data_valid afterwards sets err_o.
- With DDR_ARB_WR_PRIORITY_EN, write on port 3 and read on port 0 both pending, rr_ptr = 0 -> port 3 granted first.

Source files
------------

// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the DDR port arbiter: MIG command codes, the
// arbiter FSM state type, the read-tag record and the round-robin picker.
package ddr_arb_pkg;

  localparam logic [2:0] CMD_WRITE = 3'd0;
  localparam logic [2:0] CMD_READ  = 3'd1;

  // Port indices are sized for the largest supported arbiter (8 ports).
  localparam int MAX_PORTS  = 8;
  localparam int PORT_IDX_W = 3;
  localparam int IDX_W      = PORT_IDX_W + 1;
  localparam int TAG_CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_WR,
    ST_RD,
    ST_DONE
  } arb_state_e;

  typedef struct packed {
    logic [PORT_IDX_W-1:0] port;
    logic [TAG_CNT_W-1:0]  cnt;
  } rd_tag_t;

  // First set bit of elig at or after ptr, wrapping at num. Returns ptr when
  // nothing is eligible; callers only use the result when something is.
  function automatic logic [PORT_IDX_W-1:0] rr_select(
    input logic [MAX_PORTS-1:0]  elig,
    input logic [PORT_IDX_W-1:0] ptr,
    input logic [IDX_W-1:0]      num
  );
    logic [PORT_IDX_W-1:0] sel;
    logic                  found;
    logic [IDX_W-1:0]      idx;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      idx = {1'b0, ptr} + IDX_W'(i);
      if (idx >= num) idx = idx - num;
      if (!found && (IDX_W'(i) < num) && elig[idx[PORT_IDX_W-1:0]]) begin
        sel   = idx[PORT_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/ddr_rd_tag_fifo.sv
// In-order tag FIFO for outstanding read bursts. Each entry records the
// issuing port and the burst length; the head entry carries a beat counter
// and retires itself on its last returned beat.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i/push_tag_i enqueue a tag (ignored when full)
//   beat_i            one read beat returned for the head entry
//   empty_o, full_o   occupancy flags
//   head_port_o       port owning the head entry
module ddr_rd_tag_fifo
  import ddr_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  rd_tag_t               push_tag_i,
  input  logic                  beat_i,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [PORT_IDX_W-1:0] head_port_o
);

  localparam int AW = $clog2(DEPTH);

  rd_tag_t              mem_q [DEPTH];
  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  logic [TAG_CNT_W-1:0] head_cnt_q;
  rd_tag_t              head;
  logic                 head_last, beat, pop, push;

  assign head        = mem_q[rd_ptr_q[AW-1:0]];
  assign head_port_o = head.port;
  assign empty_o     = (wr_ptr_q == rd_ptr_q);
  assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_last   = (head_cnt_q == head.cnt - TAG_CNT_W'(1));
  assign beat        = beat_i & ~empty_o;
  assign pop         = beat & head_last;
  assign push        = push_i & ~full_o;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_tag_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      head_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        head_cnt_q <= '0;
      end else if (beat) begin
        head_cnt_q <= head_cnt_q + TAG_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one MIG user interface between NUM_PORTS
// linear-burst requesters. Issues write/read commands for the granted port,
// streams its write FIFO head to app_wdf_data, and routes read beats back to
// the issuing port in order through ddr_rd_tag_fifo.
// Build option: DDR_ARB_WR_PRIORITY_EN -- eligible writes win over reads
// (round-robin among writes first, then among reads).
// Ports:
//   ui_clk, ui_rst_i           clock, synchronous active-high reset
//   req_*_i                    per-port burst request (level, held to done_o)
//   wdata_i / wdata_pop_o      per-port FWFT write FIFO heads and pops
//   grant_o, done_o            burst in progress / burst finished pulse
//   rdata_o, rdata_vld_o, err_o  read return and orphan-beat flag
//   app_*                      MIG user interface
//
// state | meaning
// IDLE  | waiting for an eligible request
// ARB   | pick a port, latch its burst, queue its read tag
// WR    | issuing write commands + data
// RD    | issuing read commands
// DONE  | pulse done_o, drop grant
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int NUM_PORTS      = 4,
  parameter int LEN_WIDTH      = 16,
  parameter int ADDR_STEP      = 8,
  parameter int TAG_DEPTH      = 4
) (
  input  logic                                ui_clk,
  input  logic                                ui_rst_i,
  input  logic [NUM_PORTS-1:0]                req_i,
  input  logic [NUM_PORTS-1:0]                req_wr_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [NUM_PORTS*LEN_WIDTH-1:0]      req_len_i,
  input  logic [NUM_PORTS*APP_DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_PORTS-1:0]                wdata_pop_o,
  output logic [NUM_PORTS-1:0]                grant_o,
  output logic [NUM_PORTS-1:0]                done_o,
  output logic [APP_DATA_WIDTH-1:0]           rdata_o,
  output logic [NUM_PORTS-1:0]                rdata_vld_o,
  output logic                                err_o,
  output logic [ADDR_WIDTH-1:0]               app_addr,
  output logic [2:0]                          app_cmd,
  output logic                                app_en,
  output logic [APP_DATA_WIDTH-1:0]           app_wdf_data,
  output logic                                app_wdf_wren,
  output logic                                app_wdf_end,
  input  logic                                app_rdy,
  input  logic                                app_wdf_rdy,
  input  logic [APP_DATA_WIDTH-1:0]           app_rd_data,
  input  logic                                app_rd_data_valid
);

  arb_state_e                state_q;
  logic [PORT_IDX_W-1:0]     rr_ptr_q, gnt_idx_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [LEN_WIDTH-1:0]      len_q, cnt_q;
  logic [NUM_PORTS-1:0]      grant_q, done_q, rdata_vld_q;
  logic [APP_DATA_WIDTH-1:0] rdata_q;
  logic                      err_q;

  logic [NUM_PORTS-1:0]      elig, sel_oh, gnt_oh, head_oh;
  logic [PORT_IDX_W-1:0]     arb_sel_d, rr_ptr_d, head_port;
  logic                      sel_wr;
  logic [ADDR_WIDTH-1:0]     sel_addr;
  logic [LEN_WIDTH-1:0]      sel_len;
  logic [APP_DATA_WIDTH-1:0] wdata_sel;
  logic                      tag_full, tag_empty, tag_push;
  logic                      wr_beat, rd_beat;
  rd_tag_t                   push_tag;

  // Reads are held off while every tag slot is in use; writes never are.
  assign elig = req_i & (req_wr_i | {NUM_PORTS{~tag_full}});

`ifdef DDR_ARB_WR_PRIORITY_EN
  logic [NUM_PORTS-1:0] elig_wr;
  assign elig_wr   = elig & req_wr_i;
  assign arb_sel_d = (|elig_wr)
                   ? rr_select(MAX_PORTS'(elig_wr), rr_ptr_q, IDX_W'(NUM_PORTS))
                   : rr_select(MAX_PORTS'(elig), rr_ptr_q, IDX_W'(NUM_PORTS));
`else
  assign arb_sel_d = rr_select(MAX_PORTS'(elig), rr_ptr_q, IDX_W'(NUM_PORTS));
`endif

  assign rr_ptr_d = (arb_sel_d == PORT_IDX_W'(NUM_PORTS - 1))
                  ? '0 : arb_sel_d + PORT_IDX_W'(1);

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_oh    = '0;
    gnt_oh    = '0;
    head_oh   = '0;
    wdata_sel = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (arb_sel_d == PORT_IDX_W'(p)) begin
        sel_wr    = req_wr_i[p];
        sel_addr  = req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len   = req_len_i[p*LEN_WIDTH +: LEN_WIDTH];
        sel_oh[p] = 1'b1;
      end
      if (gnt_idx_q == PORT_IDX_W'(p)) begin
        gnt_oh[p] = 1'b1;
        wdata_sel = wdata_i[p*APP_DATA_WIDTH +: APP_DATA_WIDTH];
      end
      if (head_port == PORT_IDX_W'(p)) head_oh[p] = 1'b1;
    end
  end

  assign wr_beat      = (state_q == ST_WR) & app_rdy & app_wdf_rdy;
  assign rd_beat      = (state_q == ST_RD) & app_rdy;
  assign app_en       = wr_beat | rd_beat;
  assign app_cmd      = (state_q == ST_RD) ? CMD_READ : CMD_WRITE;
  assign app_addr     = addr_q;
  assign app_wdf_wren = wr_beat;
  assign app_wdf_end  = wr_beat;
  assign app_wdf_data = (state_q == ST_WR) ? wdata_sel : '0;
  assign wdata_pop_o  = wr_beat ? gnt_oh : '0;
  assign grant_o      = grant_q;
  assign done_o       = done_q;
  assign rdata_o      = rdata_q;
  assign rdata_vld_o  = rdata_vld_q;
  assign err_o        = err_q;

  // Zero-length reads never reach the MIG, so they get no tag.
  assign tag_push      = (state_q == ST_ARB) & (|elig) & ~sel_wr & (sel_len != '0);
  assign push_tag.port = arb_sel_d;
  assign push_tag.cnt  = TAG_CNT_W'(sel_len);

  ddr_rd_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk_i       (ui_clk),
    .rst_i       (ui_rst_i),
    .push_i      (tag_push),
    .push_tag_i  (push_tag),
    .beat_i      (app_rd_data_valid),
    .empty_o     (tag_empty),
    .full_o      (tag_full),
    .head_port_o (head_port)
  );

  always_ff @(posedge ui_clk) begin
    if (ui_rst_i) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: if (|elig) state_q <= ST_ARB;
        ST_ARB: begin
          if (|elig) begin
            gnt_idx_q <= arb_sel_d;
            addr_q    <= sel_addr;
            len_q     <= sel_len;
            cnt_q     <= '0;
            rr_ptr_q  <= rr_ptr_d;
            if (sel_len == '0) begin
              done_q  <= sel_oh;
              state_q <= ST_DONE;
            end else begin
              grant_q <= sel_oh;
              state_q <= sel_wr ? ST_WR : ST_RD;
            end
          end else begin
            // Requester withdrew between IDLE and ARB.
            state_q <= ST_IDLE;
          end
        end
        ST_WR, ST_RD: begin
          if (app_en) begin
            addr_q <= addr_q + ADDR_WIDTH'(ADDR_STEP);
            cnt_q  <= cnt_q + LEN_WIDTH'(1);
            if (cnt_q == len_q - LEN_WIDTH'(1)) begin
              grant_q <= '0;
              done_q  <= grant_q;
              state_q <= ST_DONE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ui_clk) begin
    if (ui_rst_i) begin
      rdata_q     <= '0;
      rdata_vld_q <= '0;
      err_q       <= 1'b0;
    end else begin
      rdata_vld_q <= '0;
      if (app_rd_data_valid) begin
        if (tag_empty) begin
          err_q <= 1'b1;
        end else begin
          rdata_q     <= app_rd_data;
          rdata_vld_q <= head_oh;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
module tb_ddr_port_arbiter;

  localparam int NP = 4;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int LW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   req_i, req_wr_i;
  logic [AW-1:0]   addr_a [NP];
  logic [LW-1:0]   len_a [NP];
  int              wcnt [NP];
  int              pop_cnt [NP];
  logic [NP*AW-1:0] req_addr_i;
  logic [NP*LW-1:0] req_len_i;
  logic [NP*DW-1:0] wdata_i;
  logic [NP-1:0]   wdata_pop_o, grant_o, done_o, rdata_vld_o;
  logic [DW-1:0]   rdata_o, app_wdf_data, app_rd_data;
  logic            err_o, app_en, app_wdf_wren, app_wdf_end;
  logic            app_rdy, app_wdf_rdy, app_rd_data_valid;
  logic [AW-1:0]   app_addr;
  logic [2:0]      app_cmd;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int gnt_cyc, done_cyc, stall_viol;
  logic wdf_toggle;
  logic [NP-1:0] prev_grant;
  logic [127:0] beat_addr[$], beat_cmd[$], beat_data[$];
  logic [127:0] gnt_log[$], done_log[$], vld_log[$], rd_log[$];

  always #5 clk = ~clk;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      req_addr_i[p*AW +: AW] = addr_a[p];
      req_len_i[p*LW +: LW]  = len_a[p];
      wdata_i[p*DW +: DW]    = {96'h0, 8'(p), 8'h00, 16'(wcnt[p])};
    end
  end

  ddr_port_arbiter dut (
    .ui_clk            (clk),
    .ui_rst_i          (rst),
    .req_i             (req_i),
    .req_wr_i          (req_wr_i),
    .req_addr_i        (req_addr_i),
    .req_len_i         (req_len_i),
    .wdata_i           (wdata_i),
    .wdata_pop_o       (wdata_pop_o),
    .grant_o           (grant_o),
    .done_o            (done_o),
    .rdata_o           (rdata_o),
    .rdata_vld_o       (rdata_vld_o),
    .err_o             (err_o),
    .app_addr          (app_addr),
    .app_cmd           (app_cmd),
    .app_en            (app_en),
    .app_wdf_data      (app_wdf_data),
    .app_wdf_wren      (app_wdf_wren),
    .app_wdf_end       (app_wdf_end),
    .app_rdy           (app_rdy),
    .app_wdf_rdy       (app_wdf_rdy),
    .app_rd_data       (app_rd_data),
    .app_rd_data_valid (app_rd_data_valid)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] qget(input logic [127:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  task automatic clear_logs();
    beat_addr.delete(); beat_cmd.delete(); beat_data.delete();
    gnt_log.delete(); done_log.delete(); vld_log.delete(); rd_log.delete();
    stall_viol = 0;
  endtask

  // One clock: sample at negedge, requesters drop req on done, drive at posedge+1.
  task automatic cycle();
    logic [NP-1:0] popm;
    @(negedge clk);
    cyc++;
    if (app_en) begin
      beat_addr.push_back(128'(app_addr));
      beat_cmd.push_back(128'(app_cmd));
      beat_data.push_back(app_wdf_data);
    end
    if (!app_wdf_rdy && (app_wdf_wren || app_wdf_end || wdata_pop_o != '0)) stall_viol++;
    if (grant_o != '0 && grant_o != prev_grant) begin
      gnt_log.push_back(128'(grant_o));
      gnt_cyc = cyc;
    end
    prev_grant = grant_o;
    if (done_o != '0) begin
      done_log.push_back(128'(done_o));
      done_cyc = cyc;
    end
    if (rdata_vld_o != '0) begin
      vld_log.push_back(128'(rdata_vld_o));
      rd_log.push_back(rdata_o);
    end
    popm  = wdata_pop_o;
    req_i = req_i & ~done_o;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (popm[p]) begin
        wcnt[p]++;
        pop_cnt[p]++;
      end
    end
    if (wdf_toggle) app_wdf_rdy = ~app_wdf_rdy;
  endtask

  task automatic run_until(input int ndone, input int budget, input string tag);
    int n;
    n = 0;
    while (done_log.size() < ndone && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, 128'(done_log.size()), 128'(ndone));
  endtask

  task automatic set_req(input int p, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
    addr_a[p]   = a;
    len_a[p]    = l;
    req_wr_i[p] = wr;
    req_i[p]    = 1'b1;
  endtask

  task automatic return_beats(input int n, input logic [127:0] base);
    for (int k = 0; k < n; k++) begin
      app_rd_data_valid = 1'b1;
      app_rd_data       = base + 128'(k);
      cycle();
    end
    app_rd_data_valid = 1'b0;
    repeat (3) cycle();
  endtask

  initial begin
    rst = 1'b1;
    req_i = '0; req_wr_i = '0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0; app_rd_data = '0;
    wdf_toggle = 1'b0; prev_grant = '0; stall_viol = 0; gnt_cyc = 0; done_cyc = 0;
    for (int p = 0; p < NP; p++) begin
      addr_a[p] = '0; len_a[p] = '0; wcnt[p] = 0; pop_cnt[p] = 0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_app_en", 128'(app_en), 128'(0));
    chk("rst_grant", 128'(grant_o), 128'(0));
    chk("rst_done", 128'(done_o), 128'(0));
    chk("rst_vld_err", 128'({rdata_vld_o, err_o}), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Port 0 write, len 4 at 0x100
    clear_logs();
    set_req(0, 1'b1, 28'h100, 16'd4);
    run_until(1, 30, "t1_done_seen");
    chk("t1_beats", 128'(beat_addr.size()), 128'(4));
    for (int i = 0; i < 4; i++) chk("t1_addr", qget(beat_addr, i), 128'(28'h100 + 8*i));
    chk("t1_cmd", qget(beat_cmd, 0), 128'(3'd0));
    chk("t1_data3", qget(beat_data, 3), 128'h0000_0003);
    chk("t1_pops", 128'(pop_cnt[0]), 128'(4));
    chk("t1_done_port", qget(done_log, 0), 128'(4'b0001));
    chk("t1_done_lat", 128'(done_cyc - gnt_cyc), 128'(4));
    repeat (2) cycle();

    // Ports 1 and 2 read len 2 each; grant order 1 then 2, in-order return
    clear_logs();
    set_req(1, 1'b0, 28'h200, 16'd2);
    set_req(2, 1'b0, 28'h300, 16'd2);
    run_until(2, 60, "t3_done_seen");
    chk("t3_gnt0", qget(gnt_log, 0), 128'(4'b0010));
    chk("t3_gnt1", qget(gnt_log, 1), 128'(4'b0100));
    chk("t3_addr1", qget(beat_addr, 1), 128'(28'h208));
    chk("t3_addr2", qget(beat_addr, 2), 128'(28'h300));
    chk("t3_cmd", qget(beat_cmd, 0), 128'(3'd1));
    return_beats(4, 128'hA0);
    chk("t3_vld0", qget(vld_log, 0), 128'(4'b0010));
    chk("t3_vld1", qget(vld_log, 1), 128'(4'b0010));
    chk("t3_vld2", qget(vld_log, 2), 128'(4'b0100));
    chk("t3_vld3", qget(vld_log, 3), 128'(4'b0100));
    chk("t3_rdata2", qget(rd_log, 2), 128'hA2);

    // rr_ptr now at 3: writes on ports 0 and 3 -> 3 first
    clear_logs();
    set_req(0, 1'b1, 28'h500, 16'd1);
    set_req(3, 1'b1, 28'h600, 16'd1);
    run_until(2, 40, "t3b_done_seen");
    chk("t3b_gnt0", qget(gnt_log, 0), 128'(4'b1000));
    chk("t3b_gnt1", qget(gnt_log, 1), 128'(4'b0001));

    // Port 1 write len 3 with app_wdf_rdy toggling, address wraps
    clear_logs();
    pop_cnt[1] = 0;
    wdf_toggle = 1'b1;
    set_req(1, 1'b1, 28'hFFF_FFF8, 16'd3);
    run_until(1, 40, "t2_done_seen");
    wdf_toggle  = 1'b0;
    app_wdf_rdy = 1'b1;
    chk("t2_beats", 128'(beat_addr.size()), 128'(3));
    chk("t2_addr0", qget(beat_addr, 0), 128'(28'hFFF_FFF8));
    chk("t2_addr1", qget(beat_addr, 1), 128'(28'h000_0000));
    chk("t2_addr2", qget(beat_addr, 2), 128'(28'h000_0008));
    chk("t2_stall", 128'(stall_viol), 128'(0));
    chk("t2_pops", 128'(pop_cnt[1]), 128'(3));
    chk("t2_data2", qget(beat_data, 2), 128'h0100_0002);
    repeat (2) cycle();

    // Fill the tag FIFO with four reads (rr_ptr at 2)
    clear_logs();
    for (int p = 0; p < NP; p++) set_req(p, 1'b0, 28'(32'h1000 * (p + 1)), 16'd1);
    run_until(4, 100, "t4_fill_done");
    chk("t4_order0", qget(gnt_log, 0), 128'(4'b0100));
    chk("t4_order3", qget(gnt_log, 3), 128'(4'b0010));
    // Fifth read blocked, write still granted
    clear_logs();
    set_req(0, 1'b0, 28'h700, 16'd1);
    set_req(1, 1'b1, 28'h800, 16'd1);
    repeat (20) cycle();
    chk("t4_wr_granted", 128'(done_log.size()), 128'(1));
    chk("t4_wr_port", qget(done_log, 0), 128'(4'b0010));
    chk("t4_rd_blocked", 128'(gnt_log.size()), 128'(1));
    app_rd_data_valid = 1'b1;
    app_rd_data       = 128'hB0;
    cycle();
    app_rd_data_valid = 1'b0;
    run_until(2, 30, "t4_rd_after_pop");
    chk("t4_rd_port", qget(done_log, 1), 128'(4'b0001));
    chk("t4_first_vld", qget(vld_log, 0), 128'(4'b0100));
    chk("t4_first_data", qget(rd_log, 0), 128'hB0);
    vld_log.delete();
    return_beats(4, 128'hC0);
    chk("t4_drain0", qget(vld_log, 0), 128'(4'b1000));
    chk("t4_drain1", qget(vld_log, 1), 128'(4'b0001));
    chk("t4_drain2", qget(vld_log, 2), 128'(4'b0010));
    chk("t4_drain3", qget(vld_log, 3), 128'(4'b0001));

    // Zero-length burst
    clear_logs();
    set_req(3, 1'b1, 28'h900, 16'd0);
    run_until(1, 20, "t5_done_seen");
    chk("t5_done_port", qget(done_log, 0), 128'(4'b1000));
    chk("t5_no_cmd", 128'(beat_addr.size()), 128'(0));
    chk("t5_no_grant", 128'(gnt_log.size()), 128'(0));
    repeat (2) cycle();

    // Reset in the middle of a write burst, then a stray read beat
    clear_logs();
    set_req(2, 1'b1, 28'h400, 16'd8);
    for (int n = 0; n < 30 && beat_addr.size() < 3; n++) cycle();
    chk("t6_burst_running", 128'(grant_o), 128'(4'b0100));
    rst   = 1'b1;
    req_i = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_cmd", 128'({app_en, app_wdf_wren, app_wdf_end}), 128'(0));
    chk("t6_rst_addr", 128'(app_addr), 128'(0));
    chk("t6_rst_ports", 128'({grant_o, done_o, wdata_pop_o, rdata_vld_o}), 128'(0));
    chk("t6_rst_err", 128'(err_o), 128'(0));
    @(posedge clk); #1;
    app_rd_data_valid = 1'b1;
    app_rd_data       = 128'hDEAD;
    @(posedge clk); #1;
    app_rd_data_valid = 1'b0;
    @(negedge clk);
    chk("t6_err_set", 128'(err_o), 128'(1));
    chk("t6_stray_dropped", 128'(rdata_vld_o), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_err_sticky", 128'(err_o), 128'(1));
    @(posedge clk); #1;

    // Write on 3 vs read on 0 with rr_ptr back at 0
    clear_logs();
    prev_grant = '0;
    set_req(3, 1'b1, 28'hA00, 16'd1);
    set_req(0, 1'b0, 28'hB00, 16'd1);
    run_until(2, 40, "t7_done_seen");
`ifdef DDR_ARB_WR_PRIORITY_EN
    chk("t7_first", qget(gnt_log, 0), 128'(4'b1000));
    chk("t7_second", qget(gnt_log, 1), 128'(4'b0001));
`else
    chk("t7_first", qget(gnt_log, 0), 128'(4'b0001));
    chk("t7_second", qget(gnt_log, 1), 128'(4'b1000));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
